dbus_sram_bridge: RTL
=====================

# dbus_sram_bridge

Bridges the CPU data-bus port (`dmem_req`/`dmem_resp` of `mycpu`) to an SRAM-like split-transaction bus (`req`/`addr_ok`/`data_ok`). It sits directly downstream of the core's memory stage and replaces the ad-hoc handshake logic formerly inlined in the top level. It holds exactly one outstanding transaction, registers all request fields, and returns a one-cycle completion pulse to the core. It optionally performs fixed kseg0/kseg1 address translation.

## Interface
Parameters:
- none (translation is macro-controlled, see Configuration)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `dmem_req`  in  `dbus_req_t`  fields `valid`, `addr[31:0]`, `size[1:0]`, `strobe[3:0]`, `data[31:0]`; held stable by the core until completion
- `dmem_resp`  out  `dbus_resp_t`  fields `addr_ok`, `data_ok`, `data[31:0]`
- `data_req`  out  1  SRAM request valid
- `data_wr`  out  1  1 = write
- `data_size`  out  2  0 = byte, 1 = half, 2 = word
- `data_addr`  out  32  physical (or pass-through) address
- `data_wdata`  out  32  write data
- `data_addr_ok`  in  1  slave accepted the request this cycle
- `data_data_ok`  in  1  slave completed the request this cycle
- `data_rdata`  in  32  read data, valid with `data_data_ok`

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: when `dmem_req.valid` is high, capture addr (translated), size, `strobe != 0` as wr, and data into registers. Pulse `dmem_resp.addr_ok` for that cycle. Go to REQ.
- REQ: `data_req` = 1, driven from registers only.
  - `data_addr_ok` & `data_data_ok` in the same cycle: capture `data_rdata`, go to RESP.
  - `data_addr_ok` alone: go to WAIT.
  - Otherwise stay in REQ.
- WAIT: `data_req` = 0. On `data_data_ok`, capture `data_rdata` and go to RESP.
- RESP: `dmem_resp.data_ok` = 1 for exactly one cycle, with `dmem_resp.data` = captured rdata. For writes, data is the captured value and is don't-care to the core. Unconditionally return to IDLE.
- The core must not re-present a completed request in the cycle after RESP. In that cycle IDLE treats `valid` as a new request.
- `data_data_ok` in IDLE or REQ without `addr_ok` is a protocol violation and is ignored.
- `data_addr_ok` outside REQ is ignored.
- `data_size` is passed unchanged. No alignment checking; exceptions are raised upstream.

## Timing
- Reset (synchronous, checked every edge, overrides everything, including mid-transaction):
  - state IDLE
  - `data_req`, `data_wr`, `dmem_resp.addr_ok`, `dmem_resp.data_ok` = 0
  - `data_addr`, `data_wdata`, `data_size`, `dmem_resp.data` = 0
  - Any slave transaction in flight is abandoned; the slave is reset in the same domain.
- All SRAM-side outputs are registered. There is no combinational path from `dmem_req` or any slave input to any output.
- Minimum latency: request seen in cycle 0, `data_req` in cycle 1, `addr_ok`+`data_ok` in cycle 1, `dmem_resp.data_ok` in cycle 2.
- Typical: `addr_ok` in cycle 1, `data_ok` in cycle 2, completion in cycle 3.
- Maximum throughput: one transaction per 3 cycles (IDLE, REQ, RESP).
- `data_req` stays high across any number of REQ cycles with stable fields until `addr_ok`.

## Configuration
- `DBUS_ADDR_TRANSLATE_EN` defined: when `addr[31:30] == 2'b10` (kseg0/kseg1, 0x8000_0000–0xBFFF_FFFF), `data_addr[31:29]` = 3'b000. All other addresses pass unchanged. Example: 0xBFC0_0000 → 0x1FC0_0000, 0x8000_1000 → 0x0000_1000.
- Not defined: `data_addr` = the captured virtual address, unchanged.

## Structure
- `dbus_req_t`, `dbus_resp_t` and the size encodings live in the shared `mips.svh` package. The bridge state enum is local.
- One combinational sub-module, `dbus_addr_xlate` (32-bit vaddr in, paddr out). It contains the `DBUS_ADDR_TRANSLATE_EN` conditional and is reusable for the instruction bus.

## Test plan
- Word read to 0xBFC0_0004; slave gives `addr_ok` in cycle 1 and `data_ok`+0xDEADBEEF in cycle 2 → `data_addr` = 0x1FC0_0004 (macro on); `dmem_resp.data_ok` in cycle 3 with data 0xDEADBEEF.
- Byte write, strobe 4'b0010, data 0x0000AB00, addr 0x0000_0101; slave holds `addr_ok` low for 4 cycles → `data_req` high 5 cycles with stable fields, `data_wr` = 1, `data_size` = 0; exactly one `data_ok` pulse.
- Same-cycle `addr_ok`+`data_ok` in REQ with rdata 0x12345678 → completion in cycle 2; WAIT never entered.
- Back-to-back reads (valid stays high, addr changes after `data_ok`) → second `data_req` asserts 2 cycles after the first completion. No duplicate transaction.
- Reset asserted while in WAIT → next cycle all outputs 0 and state IDLE. A late `data_data_ok` after reset produces no `dmem_resp.data_ok`.
- Macro off, read 0x8000_0000 → `data_addr` = 0x8000_0000.

Source files
------------

// File: rtl/dbus_sram_bridge_pkg.sv
// Shared data-bus types for the CPU data port and its SRAM-side bridge.
package dbus_sram_bridge_pkg;

  // Access size encodings carried on dmem_req.size and data_size.
  localparam logic [1:0] SizeByte = 2'd0;
  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeWord = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_addr_xlate.sv
// Fixed kseg0/kseg1 address translation, combinational.
// Enabled by defining DBUS_ADDR_TRANSLATE_EN; otherwise the address passes through.
module dbus_addr_xlate (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

`ifdef DBUS_ADDR_TRANSLATE_EN
  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map onto the low 512 MiB.
  always_comb begin
    paddr = vaddr;
    if (vaddr[31:30] == 2'b10) begin
      paddr[31:29] = 3'b000;
    end
  end
`else
  assign paddr = vaddr;
`endif

endmodule

// File: rtl/dbus_sram_bridge.sv
// Bridge from the core data port to an SRAM-like split-transaction bus.
// One outstanding transaction; all outputs registered.
// Address translation is controlled by the DBUS_ADDR_TRANSLATE_EN macro.
module dbus_sram_bridge
  import dbus_sram_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dmem_req,
  output dbus_resp_t  dmem_resp,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q;
  logic        resp_addr_ok_q;
  logic        resp_data_ok_q;
  logic [31:0] resp_data_q;
  logic [31:0] paddr;

  dbus_addr_xlate u_xlate (
    .vaddr (dmem_req.addr),
    .paddr (paddr)
  );

  assign dmem_resp.addr_ok = resp_addr_ok_q;
  assign dmem_resp.data_ok = resp_data_ok_q;
  assign dmem_resp.data    = resp_data_q;

  // Transaction FSM: captures the request, drives the slave, returns a one-cycle completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      data_req       <= 1'b0;
      data_wr        <= 1'b0;
      data_size      <= 2'd0;
      data_addr      <= 32'd0;
      data_wdata     <= 32'd0;
      resp_addr_ok_q <= 1'b0;
      resp_data_ok_q <= 1'b0;
      resp_data_q    <= 32'd0;
    end else begin
      // Both core-side strobes are single-cycle pulses.
      resp_addr_ok_q <= 1'b0;
      resp_data_ok_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dmem_req.valid) begin
            data_addr      <= paddr;
            data_size      <= dmem_req.size;
            data_wr        <= (dmem_req.strobe != 4'b0000);
            data_wdata     <= dmem_req.data;
            data_req       <= 1'b1;
            resp_addr_ok_q <= 1'b1;
            state_q        <= StReq;
          end
        end
        StReq: begin
          // A data_ok without addr_ok here is a protocol violation and is ignored.
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              resp_data_q    <= data_rdata;
              resp_data_ok_q <= 1'b1;
              state_q        <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (data_data_ok) begin
            resp_data_q    <= data_rdata;
            resp_data_ok_q <= 1'b1;
            state_q        <= StResp;
          end
        end
        StResp: begin
          // The core still holds valid this cycle; the request is only re-sampled in IDLE.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
